fetch_queue: RTL and testbench

//  Instruction queue between the fetch front end and the decode stage. Buffers {pc, instr}

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_queue_mem.sv | 23 ++
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path types and constants used by the instruction queue.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int FETCH_QUEUE_DEPTH = 4;
  localparam logic [31:0] BUBBLE_INSTR = '0;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one synchronous write port, one asynchronous read port.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  fetch_entry_t             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output fetch_entry_t             rd_data
);

  fetch_entry_t storage [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) storage[wr_addr] <= wr_data;
  end

  assign rd_data = storage[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode; registered full stalls the front end.
// Optional same-cycle bypass into an empty queue is enabled by FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_instr,
  output logic                     full,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_instr,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW:0]  wptr, rptr, count_next;
  logic         empty, push, wr_en, rd_pop, bypass_take;
  fetch_entry_t wr_entry, rd_entry;

  assign empty    = (wptr == rptr);
  assign push     = in_valid & ~full;
  assign rd_pop   = ~empty & out_ready;
  assign wr_entry = '{pc: in_pc, instr: in_instr};

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit  = empty & in_valid & ~flush;
  assign bypass_take = bypass_hit & out_ready;

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = BUBBLE_INSTR;
    if (!empty) begin
      out_valid = 1'b1;
      out_pc    = rd_entry.pc;
      out_instr = rd_entry.instr;
    end else if (bypass_hit) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
    end
  end
`else
  assign bypass_take = 1'b0;

  always_comb begin
    out_valid = ~empty;
    out_pc    = empty ? '0 : rd_entry.pc;
    out_instr = empty ? BUBBLE_INSTR : rd_entry.instr;
  end
`endif

  // A bypassed-and-consumed entry never touches storage; flush discards the push.
  assign wr_en = push & ~bypass_take & ~flush;

  always_comb begin
    count_next = count;
    case ({wr_en, rd_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      wptr  <= wptr + {{AW{1'b0}}, wr_en};
      rptr  <= rptr + {{AW{1'b0}}, rd_pop};
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
    end
  end

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr[AW-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rptr[AW-1:0]),
    .rd_data (rd_entry)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed pushes queue expected pcs, a negedge monitor checks the head.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_pc;
  logic [WIDTH-1:0] in_instr;
  logic             full;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_instr;
  logic             flush;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .full      (full),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h1300_0000 | pc;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Expected pcs are queued when the bench knows the push will be accepted.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic rdy,
                               input logic fl, input logic accept);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = v ? instr_of(pc) : 32'h0;
    out_ready = rdy;
    flush     = fl;
    if (fl) exp_q.delete();
    else if (accept) exp_q.push_back(pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                      input logic fl, input logic accept);
    applyStimulus(v, pc, rdy, fl, accept);
    tick();
  endtask

  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_head: got pc 0x%08h expected no valid entry", out_pc);
        end else begin
          checkOutput("head_pc", out_pc, exp_q[0]);
          checkOutput("head_instr", out_instr, instr_of(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        checkOutput("bubble_pc", out_pc, 32'h0);
        checkOutput("bubble_instr", out_instr, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish within 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset_count", 32'(count), 0);
    checkOutput("reset_full", 32'(full), 0);
    checkOutput("reset_valid", 32'(out_valid), 0);

    // Reset in the middle of operation.
    step(1, 32'h100, 0, 0, 1);
    step(1, 32'h104, 0, 0, 1);
    step(1, 32'h108, 0, 0, 1);
    checkOutput("fill3_count", 32'(count), 3);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    checkOutput("midreset_count", 32'(count), 0);
    checkOutput("midreset_full", 32'(full), 0);
    checkOutput("midreset_valid", 32'(out_valid), 0);
    checkOutput("midreset_pc", out_pc, 0);
    checkOutput("midreset_instr", out_instr, 0);

    // Fill to full, then a rejected fifth push.
    for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 0, 0, 1);
    checkOutput("full_flag", 32'(full), 1);
    checkOutput("full_count", 32'(count), 4);
    step(1, 32'h10, 0, 0, 0);
    checkOutput("reject_count", 32'(count), 4);
    checkOutput("reject_full", 32'(full), 1);
    checkOutput("reject_head", out_pc, 32'h0);

    // Full with push and pop together: only the pop happens.
    step(1, 32'h10, 1, 0, 0);
    checkOutput("fullpop_count", 32'(count), 3);
    checkOutput("fullpop_head", out_pc, 32'h4);
    checkOutput("fullpop_full", 32'(full), 0);

    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    checkOutput("drain_count", 32'(count), 0);

    // Walk the read pointer to index 3 with pc 0x0 at the head, then stream.
    step(1, 32'hF0, 0, 0, 1);
    step(1, 32'hF4, 1, 0, 1);
    step(1, 32'hF8, 1, 0, 1);
    step(1, 32'h00, 1, 0, 1);
    checkOutput("stream_start_count", 32'(count), 1);
    checkOutput("stream_start_head", out_pc, 32'h0);
    for (int i = 1; i <= 10; i++) begin
      step(1, 32'(i * 4), 1, 0, 1);
      checkOutput("stream_count", 32'(count), 1);
    end
    checkOutput("stream_end_head", out_pc, 32'h28);

    // Flush at count 2 with simultaneous push and pop.
    step(1, 32'h2C, 0, 0, 1);
    checkOutput("preflush_count", 32'(count), 2);
    step(1, 32'h30, 1, 1, 0);
    checkOutput("flush_count", 32'(count), 0);
    checkOutput("flush_valid", 32'(out_valid), 0);
    checkOutput("flush_full", 32'(full), 0);
    step(1, 32'h40, 0, 0, 1);
    checkOutput("postflush_valid", 32'(out_valid), 1);
    checkOutput("postflush_head", out_pc, 32'h40);
    checkOutput("postflush_count", 32'(count), 1);
    step(0, 0, 1, 0, 0);
    checkOutput("postflush_drain", 32'(count), 0);

    // Push into an empty queue with decode ready.
    applyStimulus(1, 32'h80, 1, 0, 1);
    #2;
`ifdef FETCH_QUEUE_BYPASS_EN
    checkOutput("bypass_valid", 32'(out_valid), 1);
    checkOutput("bypass_pc", out_pc, 32'h80);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("bypass_count", 32'(count), 0);
`else
    checkOutput("nobypass_valid", 32'(out_valid), 0);
    tick();
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("nobypass_head", out_pc, 32'h80);
    checkOutput("nobypass_count", 32'(count), 1);
    tick();
    checkOutput("nobypass_drain", 32'(count), 0);
`endif

    step(0, 0, 0, 0, 0);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
